mem_d_resp_model: RTL and testbench
===================================

MEM_D_RESP_MODEL -- requirements
Module: mem_d_resp_model

Interface
REQ-001 SHALL have parameter TAG_W, default 11, request/response tag width.
REQ-002 SHALL have parameter DEPTH, default 4, maximum outstanding requests (power of two, >=2).
REQ-003 SHALL have parameter LATENCY, default 2, minimum accept-to-ack cycles (>=1).
REQ-004 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-005 SHALL have ports, clock and reset first: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: mem_d_addr_i in 32, byte address; mem_d_data_wr_i in 32, write data; mem_d_rd_i in 1, read request; mem_d_wr_i in 4, byte write strobes; mem_d_req_tag_i in TAG_W, request tag.
REQ-007 SHALL have ports: mem_d_accept_o out 1, request accepted; mem_d_ack_o out 1, response valid; mem_d_data_rd_o out 32, read data; mem_d_resp_tag_o out TAG_W, response tag; mem_d_error_o out 1, response error; outstanding_o out $clog2(DEPTH)+1, current queue occupancy.

Function
REQ-008 SHALL treat a request as present when mem_d_rd_i=1 or mem_d_wr_i!=0, and accepted when present and mem_d_accept_o=1 in the same clk edge.
REQ-009 SHALL drive mem_d_accept_o = (outstanding_o < DEPTH), combinationally from registered occupancy; no same-cycle bypass when full and retiring.
REQ-010 SHALL use word index mem_d_addr_i[$clog2(MEM_WORDS)+1:2]; address bits [1:0] ignored.
REQ-011 SHALL mark a request out of range when mem_d_addr_i >= 4*MEM_WORDS; such requests SHALL complete with error=1, data 0, no storage update.
REQ-012 SHALL apply writes to storage at the acceptance edge, per byte lane where mem_d_wr_i[n]=1.
REQ-013 SHALL sample read data at the acceptance edge, so a read accepted after a write to the same word returns the written data.
REQ-014 SHALL, when rd and wr are both asserted, perform the write only and return data 0.
REQ-015 SHALL queue each accepted request (tag, data, error, age counter) in a DEPTH-entry circular FIFO with wrap-around head/tail pointers.
REQ-016 SHALL increment every queued entry's age each cycle, saturating at LATENCY.
REQ-017 SHALL retire at most one entry per cycle, in acceptance order, only the head, when head age >= LATENCY.
REQ-018 SHALL, for a request accepted at edge N into an empty queue, assert mem_d_ack_o for exactly one cycle after edge N+LATENCY with that request's tag, data and error.
REQ-019 SHALL drive mem_d_data_rd_o, mem_d_resp_tag_o, mem_d_error_o to 0 when mem_d_ack_o=0.
REQ-020 SHALL update occupancy +1 on accept only, -1 on retire only, unchanged on simultaneous accept and retire.

Reset
REQ-021 SHALL on rst=1 at a clk edge clear pointers, occupancy and all outputs to 0 (mem_d_accept_o becomes 1 the following cycle); in-flight requests are discarded with no ack.
REQ-022 SHALL NOT clear storage contents on reset.

Configuration
REQ-023 SHALL, with macro MEM_D_RESP_ERR_INJECT_EN defined, add input err_inject_i (1 bit); a request accepted while err_inject_i=1 SHALL suppress its write and complete with error=1, data 0.
REQ-024 SHALL, without MEM_D_RESP_ERR_INJECT_EN, omit err_inject_i and raise error only per REQ-011.

Verification
REQ-025 SHALL cover: write 0xDEADBEEF, strobes 0xF, addr 0x10, tag 5, then read addr 0x10 tag 6 -> acks LATENCY cycles after each accept, tag 6 returns 0xDEADBEEF.
REQ-026 SHALL cover: write 0x000000AA strobe 0x1 over stored 0x11223344 -> read returns 0x112233AA.
REQ-027 SHALL cover: DEPTH+1 back-to-back reads, tags 0..4 -> accept low on the fifth request until first retire; acks in order 0..4, one per cycle.
REQ-028 SHALL cover: read addr 4*MEM_WORDS (0x1000) tag 3 -> ack with error=1, data 0; storage unchanged.
REQ-029 SHALL cover: rst pulsed with 3 requests outstanding -> no acks, outstanding_o=0, accept=1 next cycle, prior storage data still readable.
REQ-030 SHALL cover, with MEM_D_RESP_ERR_INJECT_EN: write 0x55 to addr 0x20 with err_inject_i=1 -> error=1; subsequent read returns previous contents.

Source files
------------

// File: rtl/mem_d_resp_model.sv
// mem_d_resp_model: tagged data-memory responder with a minimum accept-to-ack latency and in-order responses.
// Optional error injection (input err_inject_i) is enabled by defining MEM_D_RESP_ERR_INJECT_EN.
module mem_d_resp_model #(
   parameter int TAG_W     = 11,
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 2,
   parameter int MEM_WORDS = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             mem_d_addr_i,
   input  logic [31:0]             mem_d_data_wr_i,
   input  logic                    mem_d_rd_i,
   input  logic [3:0]              mem_d_wr_i,
   input  logic [TAG_W-1:0]        mem_d_req_tag_i,
`ifdef MEM_D_RESP_ERR_INJECT_EN
   input  logic                    err_inject_i,
`endif
   output logic                    mem_d_accept_o,
   output logic                    mem_d_ack_o,
   output logic [31:0]             mem_d_data_rd_o,
   output logic [TAG_W-1:0]        mem_d_resp_tag_o,
   output logic                    mem_d_error_o,
   output logic [$clog2(DEPTH):0]  outstanding_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int AGE_W = $clog2(LATENCY + 1);

   localparam logic [32:0]      LIMIT     = 33'(4 * MEM_WORDS);
   localparam logic [AGE_W-1:0] AGE_DONE  = AGE_W'(LATENCY);
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             err;
   } entry_t;

   logic [31:0]      mem [MEM_WORDS];
   entry_t           fifo [DEPTH];
   logic [AGE_W-1:0] age [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   logic             wr_any;
   logic             present;
   logic             accept;
   logic             retire;
   logic             out_of_range;
   logic             inject;
   logic             store_en;
   logic [IDX_W-1:0] word;
   entry_t           incoming;
   logic             unused_addr_lsbs;

`ifdef MEM_D_RESP_ERR_INJECT_EN
   assign inject = err_inject_i;
`else
   assign inject = 1'b0;
`endif

   // Byte offset within the word never selects anything.
   assign unused_addr_lsbs = ^mem_d_addr_i[1:0];

   assign wr_any       = |mem_d_wr_i;
   assign present      = mem_d_rd_i | wr_any;
   assign out_of_range = {1'b0, mem_d_addr_i} >= LIMIT;
   assign word         = mem_d_addr_i[IDX_W+1:2];

   // Accept looks only at registered occupancy, so a full queue stalls even on a retiring cycle.
   assign mem_d_accept_o = count < DEPTH_CNT;
   assign accept         = present & mem_d_accept_o & ~rst;
   assign store_en       = accept & wr_any & ~out_of_range & ~inject;
   assign retire         = (count != '0) && (age[head] >= AGE_DONE);

   always_comb begin
      incoming.tag  = mem_d_req_tag_i;
      incoming.err  = out_of_range | inject;
      incoming.data = mem[word];
      if (out_of_range || inject || wr_any) begin
         incoming.data = '0;
      end
   end

   assign mem_d_ack_o      = retire;
   assign mem_d_data_rd_o  = retire ? fifo[head].data : '0;
   assign mem_d_resp_tag_o = retire ? fifo[head].tag  : '0;
   assign mem_d_error_o    = retire ? fifo[head].err  : 1'b0;
   assign outstanding_o    = count;

   // NOTE: storage, payloads and ages carry no reset; only pointers and occupancy decide what is valid.
   always_ff @(posedge clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_d_wr_i[b]) begin
               mem[word][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo[tail] <= incoming;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (accept && (tail == PTR_W'(i))) begin
            age[i] <= '0;
         end else if (age[i] < AGE_DONE) begin
            age[i] <= age[i] + AGE_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (accept) begin
            tail <= tail + PTR_W'(1);
         end
         if (retire) begin
            head <= head + PTR_W'(1);
         end
         case ({accept, retire})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_d_resp_model.sv
// Bench for mem_d_resp_model: queue-based response model, directed scenarios and randomized traffic.
// Build with MEM_D_RESP_ERR_INJECT_EN defined to also exercise err_inject_i.
module tb_mem_d_resp_model;

   localparam int TAG_W     = 11;
   localparam int DEPTH     = 4;
   localparam int LATENCY   = 4;
   localparam int MEM_WORDS = 1024;
   localparam int IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [31:0]            addr = '0;
   logic [31:0]            wdata = '0;
   logic                   rd = 1'b0;
   logic [3:0]             wr = '0;
   logic [TAG_W-1:0]       tag = '0;
   logic                   inj = 1'b0;
   logic                   accept;
   logic                   ack;
   logic [31:0]            rdata;
   logic [TAG_W-1:0]       rtag;
   logic                   err;
   logic [$clog2(DEPTH):0] outstanding;

   always #5 clk = ~clk;

   mem_d_resp_model #(
      .TAG_W     (TAG_W),
      .DEPTH     (DEPTH),
      .LATENCY   (LATENCY),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_d_addr_i     (addr),
      .mem_d_data_wr_i  (wdata),
      .mem_d_rd_i       (rd),
      .mem_d_wr_i       (wr),
      .mem_d_req_tag_i  (tag),
`ifdef MEM_D_RESP_ERR_INJECT_EN
      .err_inject_i     (inj),
`endif
      .mem_d_accept_o   (accept),
      .mem_d_ack_o      (ack),
      .mem_d_data_rd_o  (rdata),
      .mem_d_resp_tag_o (rtag),
      .mem_d_error_o    (err),
      .outstanding_o    (outstanding)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: each accepted request is due at max(accept edge + LATENCY, previous due + 1)
   // and leaves the queue on the edge after its ack cycle.
   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             err;
      int               ack_edge;
   } resp_t;

   resp_t       q[$];
   logic [31:0] mm [MEM_WORDS];
   int          e = 0;
   int          last_ack = -100;
   bit          m_acc = 0;
   int          m_acc_edge = -1;

   initial begin : model
      resp_t r;
      int    occ;
      int    w;
      forever begin
         @(posedge clk);
         e++;
         m_acc = 0;
         if (rst) begin
            q.delete();
         end else begin
            occ = q.size();
            if (occ > 0 && q[0].ack_edge + 1 == e) void'(q.pop_front());
            if ((rd || wr != 4'h0) && occ < DEPTH) begin
               w          = int'(addr[IDX_W+1:2]);
               r.tag      = tag;
               r.err      = (addr >= LIMIT) || inj;
               r.data     = (r.err || wr != 4'h0) ? 32'h0 : mm[w];
               r.ack_edge = (e + LATENCY > last_ack + 1) ? e + LATENCY : last_ack + 1;
               last_ack   = r.ack_edge;
               if (!r.err) begin
                  for (int b = 0; b < 4; b++) if (wr[b]) mm[w][8*b +: 8] = wdata[8*b +: 8];
               end
               q.push_back(r);
               m_acc      = 1;
               m_acc_edge = e;
            end
         end
      end
   end

   int ack_tags[$];
   int ack_edges[$];

   initial begin : compare
      bit exp_ack;
      forever begin
         @(negedge clk);
         if (e > 0) begin
            exp_ack = (q.size() != 0) && (q[0].ack_edge == e);
            check("accept", accept, q.size() < DEPTH);
            check("outstanding", outstanding, q.size());
            check("ack", ack, exp_ack);
            check("resp_tag", rtag, exp_ack ? q[0].tag : '0);
            check("resp_data", rdata, exp_ack ? q[0].data : 32'h0);
            check("resp_err", err, exp_ack ? q[0].err : 1'b0);
            if (ack) begin
               ack_tags.push_back(int'(rtag));
               ack_edges.push_back(e);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_inputs();
      rd = 1'b0; wr = '0; addr = '0; wdata = '0; tag = '0; inj = 1'b0;
   endtask

   // Presents one request from a falling edge and holds it until the model reports acceptance.
   task automatic send(input logic s_rd, input logic [3:0] s_wr, input logic [31:0] s_addr,
                       input logic [31:0] s_data, input logic [TAG_W-1:0] s_tag, input logic s_inj,
                       output int acc_edge, output int waited);
      bit done = 0;
      acc_edge = -1;
      waited   = 0;
      @(negedge clk);
      rd = s_rd; wr = s_wr; addr = s_addr; wdata = s_data; tag = s_tag; inj = s_inj;
      for (int k = 0; k < 64 && !done; k++) begin
         @(posedge clk);
         #1;
         if (m_acc) begin
            done     = 1;
            acc_edge = m_acc_edge;
         end else begin
            waited++;
         end
      end
      clear_inputs();
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic expect_ack(input string name, input logic [TAG_W-1:0] etag, input logic [31:0] edata,
                             input logic eerr, input int acc_edge);
      int k;
      for (k = 0; k < 64; k++) begin
         @(negedge clk);
         if (ack) break;
      end
      if (k == 64) begin
         check({name, "_timeout"}, 0, 1);
      end else begin
         check({name, "_tag"}, rtag, etag);
         check({name, "_data"}, rdata, edata);
         check({name, "_err"}, err, eerr);
         check({name, "_latency"}, e - acc_edge, LATENCY);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      check("drain_outstanding", outstanding, 0);
   endtask

   initial begin : main
      int          a;
      int          wt;
      int          waits [5];
      int          n_before;
      logic [31:0] saved;

      repeat (2) @(negedge clk);
      check("reset_accept", accept, 1);
      check("reset_outstanding", outstanding, 0);
      check("reset_ack", ack, 0);
      rst = 1'b0;

      // Give the 16-word working set known contents.
      for (int w = 0; w < 16; w++) send(1'b0, 4'hF, 32'(w * 4), $urandom, TAG_W'(w), 1'b0, a, wt);
      drain();

      // Full-word write then read-back, each acked LATENCY cycles after acceptance.
      send(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 5, 1'b0, a, wt);
      expect_ack("wr_tag5", 5, 32'h0, 1'b0, a);
      send(1'b1, 4'h0, 32'h10, 32'h0, 6, 1'b0, a, wt);
      expect_ack("rd_tag6", 6, 32'hDEADBEEF, 1'b0, a);

      // Single byte-lane merge.
      send(1'b0, 4'hF, 32'h30, 32'h11223344, 1, 1'b0, a, wt);
      expect_ack("wr_full", 1, 32'h0, 1'b0, a);
      send(1'b0, 4'h1, 32'h30, 32'h000000AA, 2, 1'b0, a, wt);
      expect_ack("wr_lane0", 2, 32'h0, 1'b0, a);
      send(1'b1, 4'h0, 32'h30, 32'h0, 3, 1'b0, a, wt);
      expect_ack("rd_merge", 3, 32'h112233AA, 1'b0, a);

      // DEPTH+1 back-to-back reads: accepts at edges 1..4, first ack after edge 5, retire at 6,
      // so the fifth request is refused on two edges before acceptance.
      ack_tags.delete();
      ack_edges.delete();
      for (int i = 0; i < 5; i++) send(1'b1, 4'h0, 32'(i * 4), 32'h0, TAG_W'(i), 1'b0, a, waits[i]);
      for (int i = 0; i < 4; i++) check("b2b_no_stall", waits[i], 0);
      check("b2b_fifth_stall", waits[4], 2);
      for (int k = 0; k < 64 && ack_tags.size() < 5; k++) @(negedge clk);
      check("b2b_ack_count", ack_tags.size(), 5);
      for (int i = 0; i < 5 && i < ack_tags.size(); i++) check("b2b_ack_order", ack_tags[i], i);
      for (int i = 0; i < 3 && i + 1 < ack_edges.size(); i++)
         check("b2b_ack_spacing", ack_edges[i+1] - ack_edges[i], 1);
      drain();

      // Out-of-range read and write both error out and leave word 0 alone.
      saved = mm[0];
      send(1'b1, 4'h0, 32'h1000, 32'h0, 3, 1'b0, a, wt);
      expect_ack("oor_rd", 3, 32'h0, 1'b1, a);
      send(1'b0, 4'hF, 32'h1000, 32'hFFFFFFFF, 4, 1'b0, a, wt);
      expect_ack("oor_wr", 4, 32'h0, 1'b1, a);
      send(1'b1, 4'h0, 32'h0, 32'h0, 7, 1'b0, a, wt);
      expect_ack("oor_word0", 7, saved, 1'b0, a);

      // Reset with three requests in flight.
      for (int i = 0; i < 3; i++) send(1'b1, 4'h0, 32'(16 + 4 * i), 32'h0, TAG_W'(8 + i), 1'b0, a, wt);
      @(negedge clk);
      check("pre_reset_outstanding", outstanding, 3);
      rst = 1'b1;
      n_before = ack_tags.size();
      @(negedge clk);
      rst = 1'b0;
      check("post_reset_outstanding", outstanding, 0);
      check("post_reset_accept", accept, 1);
      repeat (10) @(negedge clk);
      check("post_reset_no_acks", ack_tags.size() - n_before, 0);
      send(1'b1, 4'h0, 32'h10, 32'h0, 11, 1'b0, a, wt);
      expect_ack("post_reset_rd", 11, 32'hDEADBEEF, 1'b0, a);

`ifdef MEM_D_RESP_ERR_INJECT_EN
      saved = mm[8];
      send(1'b0, 4'hF, 32'h20, 32'h55, 12, 1'b1, a, wt);
      expect_ack("inject_wr", 12, 32'h0, 1'b1, a);
      send(1'b1, 4'h0, 32'h20, 32'h0, 13, 1'b0, a, wt);
      expect_ack("inject_rd", 13, saved, 1'b0, a);
`endif

      // Randomized traffic over the working set plus occasional out-of-range addresses.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rd = 1'b0;
         wr = 4'h0;
         if ($urandom_range(0, 9) >= 2) begin
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if (!rd && wr == 4'h0) rd = 1'b1;
         end
         addr  = ($urandom_range(0, 9) == 0) ? LIMIT + 32'($urandom_range(0, 4095))
                                             : {26'd0, 4'($urandom), 2'($urandom)};
         wdata = $urandom;
         tag   = TAG_W'($urandom);
`ifdef MEM_D_RESP_ERR_INJECT_EN
         inj   = ($urandom_range(0, 9) == 0);
`endif
      end
      @(negedge clk);
      clear_inputs();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
